spi_slave_byte: RTL and testbench
=================================

Name: spi_slave_byte

Overview:
- SPI target (slave) that sits on the far end of the SPI master link.
- Oversamples SCK/MOSI/SS_N in its own clock domain and deserialises MOSI into bytes.
- Serialises a one-byte transmit buffer onto MISO.
- Presents a simple valid/ready byte interface to local logic, for example a register file or loopback to the I2C-to-Wishbone bridge.

Parameters:
- CPOL, 0, SCK idle level. Leading edge = rising when 0, falling when 1.
- CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- FILL, 8'hFF, byte shifted out when no tx byte is buffered (underrun).

Ports:
- clk_i, input, 1, system clock. Must satisfy f(clk_i) >= 8 * f(sck_i).
- rst_i, input, 1, asynchronous active-high reset.
- sck_i, input, 1, SPI clock from master (asynchronous).
- mosi_i, input, 1, master-out slave-in (asynchronous).
- ss_n_i, input, 1, slave select, active low (asynchronous).
- miso_o, output, 1, slave-out data.
- miso_oe_o, output, 1, MISO output enable; high only while selected.
- tx_data_i, input, 8, byte to transmit.
- tx_valid_i, input, 1, tx_data_i is valid.
- tx_ready_o, output, 1, tx buffer empty. Transfer occurs when tx_valid_i && tx_ready_o.
- rx_data_o, output, 8, last received byte; held until the next byte completes.
- rx_valid_o, output, 1, one-cycle pulse when rx_data_o updates.
- tx_underrun_o, output, 1, one-cycle pulse when FILL is loaded instead of buffered data.
- busy_o, output, 1, high while in ACTIVE.

Behaviour:
- Input synchronisation:
  - sck_i, mosi_i, ss_n_i each pass through a 2-FF synchroniser, then a third register for edge detection.
  - Edges are seen 3 clk_i cycles after the pin change.
  - MOSI is sampled from the synchronised copy on the same cycle the edge is detected.
- Reset values:
  - miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=8'h00, rx_valid_o=0, tx_underrun_o=0, busy_o=0.
  - Internal: shift register 0, bit count 0, tx buffer empty, state IDLE.
  - Synchroniser reset values: ss_n = 1, sck = CPOL.
- Tx buffer:
  - One byte deep. Accepts on tx_valid_i && tx_ready_o; tx_ready_o drops the next cycle.
  - Frees (tx_ready_o=1) on the cycle its content is loaded into the shift register.
  - If a load and a new accept coincide, the load takes the old content and the buffer immediately refills with the new byte, so tx_ready_o stays 0.
- State machine, IDLE:
  - miso_oe_o=0; the shift register holds.
  - On a synchronised ss_n falling edge: go to ACTIVE, clear bit count, set busy_o.
  - CPHA=0: also load the shift register from the tx buffer (or FILL with a tx_underrun_o pulse), drive miso_o = MSB, and set miso_oe_o.
- State machine, ACTIVE:
  - Sample edge: shift the synchronised MOSI into the rx shift register LSB; bit count +1.
  - On the 8th sample: rx_data_o <= assembled byte (MSB first), rx_valid_o pulses 1 cycle, bit count wraps to 0.
  - Shift edge with bit count != 0: miso_o <= next tx bit, MSB first.
  - Shift edge with bit count == 0: this is a byte boundary.
    - CPHA=0: the trailing edge after the 8th sample.
    - CPHA=1: the first leading edge of each byte.
    - Load the next tx byte (or FILL with a tx_underrun_o pulse) and drive its MSB.
  - CPHA=0, first byte: already loaded at the select edge, so no extra load occurs on the first trailing edge.
  - CPHA=1: miso_oe_o is set at ss_n assertion; miso_o drives the stale bit until the first leading edge.
- Deselect:
  - Synchronised ss_n rising edge in any ACTIVE cycle returns to IDLE next cycle: miso_oe_o=0, busy_o=0, bit count cleared.
  - A partial byte is discarded, with no rx_valid_o.
  - A buffered tx byte that was not loaded is retained.
- SCK edges while deselected are ignored.
- ss_n rising and an SCK edge in the same cycle: deselect wins and the edge is ignored.
- Reset asserted mid-transfer returns immediately to reset values. The tx buffer is emptied.

Test Plan:
- Mode 0, buffer 8'hA5, master sends 8'h3C at clk_i/8 → MISO bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C with one rx_valid_o pulse; tx_ready_o rises at select-edge load.
- Two back-to-back bytes in one select, tx 8'h12 then 8'h34 written after the first load → MISO 8'h12, 8'h34; rx_valid_o pulses twice; no tx_underrun_o.
- Empty tx buffer, FILL default → MISO shifts 8'hFF; tx_underrun_o pulses once per byte.
- ss_n deasserted after 5 SCK edges → no rx_valid_o; miso_oe_o=0 within 4 clk_i cycles; next full select receives a new byte correctly with bit count reset.
- CPOL=1, CPHA=1, tx 8'hC3, master sends 8'h81 → MISO 8'hC3 valid on trailing edges; rx_data_o=8'h81.
- rst_i pulsed mid-byte with buffer full → all outputs at reset values; tx_ready_o=1; subsequent transfer shifts FILL.

Source files
------------

// File: rtl/spi_slave_byte.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_byte
//  Purpose  : SPI target that oversamples SCK/MOSI/SS_N in the clk_i domain,
//             assembles MOSI into bytes and serialises a one-byte transmit
//             buffer onto MISO, MSB first.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          system clock, at least 8x the SCK rate
//    rst_i          asynchronous active-high reset
//    sck_i/mosi_i/ss_n_i  asynchronous SPI pins from the master
//    miso_o         serial data to the master
//    miso_oe_o      MISO output enable, high while selected
//    tx_data_i/tx_valid_i/tx_ready_o  one-byte transmit buffer handshake
//    rx_data_o      last complete received byte
//    rx_valid_o     one-cycle pulse when rx_data_o updates
//    tx_underrun_o  one-cycle pulse when FILL is shifted instead of data
//    busy_o         high while a select is in progress
// ============================================================================
module spi_slave_byte #(
  parameter logic       CPOL = 1'b0,
  parameter logic       CPHA = 1'b0,
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       ss_n_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t      r_state;

  // Two synchroniser stages plus a delayed copy for edge detection
  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic        r_ss_s1,  r_ss_s2,  r_ss_d;
  logic        r_mosi_s1, r_mosi_s2;

  logic [7:0]  r_tx_sh;
  logic [7:0]  r_rx_sh;
  logic [2:0]  r_bitcnt;
  logic        r_miso;
  logic        r_miso_oe;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_underrun;
  logic        r_busy;

  logic [7:0]  r_txbuf;
  logic        r_txbuf_full;

  logic        w_sck_rise, w_sck_fall;
  logic        w_lead, w_trail;
  logic        w_sample, w_shift;
  logic        w_ss_fall, w_ss_rise;
  logic        w_load;
  logic        w_accept;
  logic [7:0]  w_load_byte;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sck_s1  <= CPOL;
      r_sck_s2  <= CPOL;
      r_sck_d   <= CPOL;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= sck_i;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_ss_s1   <= ss_n_i;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_mosi_s1 <= mosi_i;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_lead     = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail    = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample   = CPHA ? w_trail : w_lead;
  assign w_shift    = CPHA ? w_lead : w_trail;
  assign w_ss_fall  = r_ss_d & ~r_ss_s2;
  assign w_ss_rise  = ~r_ss_d & r_ss_s2;

  // A new tx byte enters the shift register either at the select edge
  // (CPHA=0 must present its MSB before the first sample) or on a shift
  // edge that starts a new byte. Deselect in the same cycle suppresses it.
  always_comb begin
    w_load = 1'b0;
    if (r_state == ST_IDLE)
      w_load = w_ss_fall & ~CPHA;
    else
      w_load = ~w_ss_rise & w_shift & (r_bitcnt == 3'd0);
  end

  assign w_load_byte = r_txbuf_full ? r_txbuf : FILL;
  assign w_accept    = tx_valid_i & ~r_txbuf_full;

  // Load reads the old buffer content; an accept in the same cycle refills it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_txbuf      <= 8'h00;
      r_txbuf_full <= 1'b0;
    end else begin
      r_txbuf_full <= (r_txbuf_full & ~w_load) | w_accept;
      if (w_accept)
        r_txbuf <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_tx_sh    <= 8'h00;
      r_rx_sh    <= 8'h00;
      r_bitcnt   <= 3'd0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (w_load) begin
        r_tx_sh    <= w_load_byte;
        r_miso     <= w_load_byte[7];
        r_underrun <= ~r_txbuf_full;
      end

      if (r_state == ST_IDLE) begin
        if (w_ss_fall) begin
          r_state   <= ST_ACTIVE;
          r_bitcnt  <= 3'd0;
          r_busy    <= 1'b1;
          r_miso_oe <= 1'b1;
        end
      end else begin
        if (w_ss_rise) begin
          // Deselect wins over any coincident SCK edge; partial byte dropped
          r_state   <= ST_IDLE;
          r_bitcnt  <= 3'd0;
          r_busy    <= 1'b0;
          r_miso_oe <= 1'b0;
        end else if (w_sample) begin
          r_rx_sh  <= {r_rx_sh[6:0], r_mosi_s2};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            r_rx_data  <= {r_rx_sh[6:0], r_mosi_s2};
            r_rx_valid <= 1'b1;
          end
        end else if (w_shift && (r_bitcnt != 3'd0)) begin
          r_tx_sh <= {r_tx_sh[6:0], 1'b0};
          r_miso  <= r_tx_sh[6];
        end
      end
    end
  end

  assign miso_o        = r_miso;
  assign miso_oe_o     = r_miso_oe;
  assign tx_ready_o    = ~r_txbuf_full;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign tx_underrun_o = r_underrun;
  assign busy_o        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_byte
//  Purpose  : Self-checking bench for spi_slave_byte. Instance A runs mode 0
//             (CPOL=0, CPHA=0), instance B runs mode 3 (CPOL=1, CPHA=1).
//             Expected rx bytes are queued when a frame is driven and popped
//             when the DUT pulses rx_valid_o.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi;
  logic       sck_a, ss_a, sck_b, ss_b;
  logic       miso_a, oe_a, rdy_a, rxv_a, und_a, busy_a;
  logic       miso_b, oe_b, rdy_b, rxv_b, und_b, busy_b;
  logic [7:0] txd_a, txd_b, rxd_a, rxd_b;
  logic       txv_a, txv_b;

  int tests = 0;
  int fails = 0;
  int und_cnt_a = 0;
  int und_cnt_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  spi_slave_byte #(.CPOL(1'b0), .CPHA(1'b0), .FILL(8'hFF)) dut_a (
    .clk_i(clk), .rst_i(rst), .sck_i(sck_a), .mosi_i(mosi), .ss_n_i(ss_a),
    .miso_o(miso_a), .miso_oe_o(oe_a), .tx_data_i(txd_a), .tx_valid_i(txv_a),
    .tx_ready_o(rdy_a), .rx_data_o(rxd_a), .rx_valid_o(rxv_a),
    .tx_underrun_o(und_a), .busy_o(busy_a)
  );

  spi_slave_byte #(.CPOL(1'b1), .CPHA(1'b1), .FILL(8'hFF)) dut_b (
    .clk_i(clk), .rst_i(rst), .sck_i(sck_b), .mosi_i(mosi), .ss_n_i(ss_b),
    .miso_o(miso_b), .miso_oe_o(oe_b), .tx_data_i(txd_b), .tx_valid_i(txv_b),
    .tx_ready_o(rdy_b), .rx_data_o(rxd_b), .rx_valid_o(rxv_b),
    .tx_underrun_o(und_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: every rx_valid pulse must match the oldest queued byte
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && rxv_a === 1'b1) begin
      check("rx_a_expected", 16'(q_a.size() != 0), 16'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("rx_a_data", {8'h00, rxd_a}, {8'h00, e});
      end
    end
    if (!rst && rxv_b === 1'b1) begin
      check("rx_b_expected", 16'(q_b.size() != 0), 16'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("rx_b_data", {8'h00, rxd_b}, {8'h00, e});
      end
    end
    if (und_a === 1'b1) und_cnt_a++;
    if (und_b === 1'b1) und_cnt_b++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_sck(input bit m3, input logic v);
    if (m3) sck_b = v; else sck_a = v;
  endtask

  task automatic set_ss(input bit m3, input logic v);
    if (m3) ss_b = v; else ss_a = v;
  endtask

  task automatic push_tx(input bit m3, input logic [7:0] d);
    int n = 0;
    while (((m3 ? rdy_b : rdy_a) !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(m3 ? "tx_ready_wait_b" : "tx_ready_wait_a", 16'(n < 500), 16'd1);
    if (m3) begin txd_b = d; txv_b = 1'b1; end
    else    begin txd_a = d; txv_a = 1'b1; end
    @(negedge clk);
    if (m3) txv_b = 1'b0; else txv_a = 1'b0;
  endtask

  // Master frame: SCK half period = 4 clk. Mode 0 samples on leading
  // edges, mode 3 on trailing edges; MISO is read just before the sample edge.
  task automatic frame(input bit m3, input int nedges, input logic [15:0] mbits,
                       input bit keep_sel, output logic [15:0] got,
                       output logic [2:0] status, output logic oe_after);
    int   s;
    logic idle;
    logic lead;
    logic is_sample;
    idle     = m3;
    got      = '0;
    s        = 0;
    oe_after = 1'b0;
    @(negedge clk);
    mosi = mbits[15];
    set_ss(m3, 1'b0);
    repeat (4) @(negedge clk);
    status = m3 ? {busy_b, oe_b, rdy_b} : {busy_a, oe_a, rdy_a};
    for (int e = 0; e < nedges; e++) begin
      lead      = ((e % 2) == 0);
      is_sample = (lead != m3);
      if (is_sample && s < 16)
        got[15 - s] = m3 ? miso_b : miso_a;
      set_sck(m3, lead ? ~idle : idle);
      if (is_sample)
        s++;
      else if (s < 16)
        mosi = mbits[15 - s];
      repeat (4) @(negedge clk);
    end
    if (!keep_sel) begin
      set_ss(m3, 1'b1);
      repeat (4) @(negedge clk);
      oe_after = m3 ? oe_b : oe_a;
      set_sck(m3, idle);
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [2:0]  st;
    logic        oe_after;
    int          u0;

    rst = 1'b1; mosi = 1'b0;
    sck_a = 1'b0; ss_a = 1'b1; sck_b = 1'b1; ss_b = 1'b1;
    txd_a = 8'h00; txd_b = 8'h00; txv_a = 1'b0; txv_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_flags_a", {10'd0, miso_a, oe_a, rdy_a, rxv_a, und_a, busy_a}, 16'b001000);
    check("reset_rxd_a", {8'h00, rxd_a}, 16'h0000);
    check("reset_flags_b", {10'd0, miso_b, oe_b, rdy_b, rxv_b, und_b, busy_b}, 16'b001000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Mode 0 single byte: tx A5, rx 3C
    push_tx(1'b0, 8'hA5);
    check("tx_ready_drop", {15'd0, rdy_a}, 16'd0);
    u0 = und_cnt_a;
    q_a.push_back(8'h3C);
    frame(1'b0, 15, 16'h3C00, 1'b0, got, st, oe_after);
    check("m0_select_status", {13'd0, st}, 16'b111);
    check("m0_miso", {8'h00, got[15:8]}, 16'h00A5);
    check("m0_no_underrun", 16'(und_cnt_a - u0), 16'd0);
    check("m0_oe_off", {15'd0, oe_after}, 16'd0);

    // Two back-to-back bytes, second written after the first load
    push_tx(1'b0, 8'h12);
    u0 = und_cnt_a;
    q_a.push_back(8'h5A);
    q_a.push_back(8'hC3);
    fork
      frame(1'b0, 31, 16'h5AC3, 1'b0, got, st, oe_after);
      push_tx(1'b0, 8'h34);
    join
    check("b2b_miso", got, 16'h1234);
    check("b2b_no_underrun", 16'(und_cnt_a - u0), 16'd0);

    // Empty buffer: FILL shifted, one underrun per byte
    u0 = und_cnt_a;
    q_a.push_back(8'h96);
    q_a.push_back(8'h0F);
    frame(1'b0, 31, 16'h960F, 1'b0, got, st, oe_after);
    check("fill_miso", got, 16'hFFFF);
    check("fill_underruns", 16'(und_cnt_a - u0), 16'd2);

    // Partial byte: 5 edges then deselect, no rx_valid expected
    frame(1'b0, 5, 16'hE700, 1'b0, got, st, oe_after);
    check("partial_oe_off", {15'd0, oe_after}, 16'd0);
    check("partial_busy_off", {15'd0, busy_a}, 16'd0);
    push_tx(1'b0, 8'h69);
    q_a.push_back(8'h5B);
    frame(1'b0, 15, 16'h5B00, 1'b0, got, st, oe_after);
    check("after_partial_miso", {8'h00, got[15:8]}, 16'h0069);

    // Mode 3: tx C3, rx 81
    push_tx(1'b1, 8'hC3);
    u0 = und_cnt_b;
    q_b.push_back(8'h81);
    frame(1'b1, 16, 16'h8100, 1'b0, got, st, oe_after);
    check("m3_select_status", {13'd0, st}, 16'b110);
    check("m3_miso", {8'h00, got[15:8]}, 16'h00C3);
    check("m3_no_underrun", 16'(und_cnt_b - u0), 16'd0);
    check("m3_ready_after", {15'd0, rdy_b}, 16'd1);

    // Reset mid-byte with the tx buffer full
    push_tx(1'b0, 8'h11);
    frame(1'b0, 6, 16'hF0F0, 1'b1, got, st, oe_after);
    push_tx(1'b0, 8'h22);
    check("midbyte_buf_full", {15'd0, rdy_a}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags_a", {10'd0, miso_a, oe_a, rdy_a, rxv_a, und_a, busy_a}, 16'b001000);
    check("midrst_rxd_a", {8'h00, rxd_a}, 16'h0000);
    ss_a = 1'b1; sck_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    u0 = und_cnt_a;
    q_a.push_back(8'hA7);
    frame(1'b0, 15, 16'hA700, 1'b0, got, st, oe_after);
    check("post_rst_fill", {8'h00, got[15:8]}, 16'h00FF);
    check("post_rst_underrun", 16'(und_cnt_a - u0), 16'd1);

    repeat (10) @(negedge clk);
    check("rx_a_drained", 16'(q_a.size()), 16'd0);
    check("rx_b_drained", 16'(q_b.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
